// File: rtl/bram_stream_reader_if.sv
// Bus bundle for bram_stream_reader: command/status, RAM read port and output stream.
interface bram_stream_reader_if #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 12
);
    logic              start_i;
    logic [10:0]       base_i;
    logic [LEN_W-1:0]  len_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic              ram_rclke_o;
    logic              ram_re_o;
    logic [10:0]       ram_raddr_o;
    logic [15:0]       ram_rdata_i;
    logic              m_valid_o;
    logic [DATA_W-1:0] m_data_o;
    logic              m_last_o;
    logic              m_ready_i;

    modport master (
        input  start_i, base_i, len_i, ram_rdata_i, m_ready_i,
        output busy_o, done_o, err_o, ram_rclke_o, ram_re_o, ram_raddr_o,
               m_valid_o, m_data_o, m_last_o
    );

    modport slave (
        output start_i, base_i, len_i, ram_rdata_i, m_ready_i,
        input  busy_o, done_o, err_o, ram_rclke_o, ram_re_o, ram_raddr_o,
               m_valid_o, m_data_o, m_last_o
    );
endinterface

// File: rtl/bram_stream_reader.sv
// Read-side master for one RAM40_4K: walks an address range and streams words out.
// Define BRAM_RD_WRAP_EN for circular addressing; otherwise ranges are clamped at DEPTH.
module bram_stream_reader #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096 / DATA_W,
    parameter int LEN_W  = 12
) (
    input logic                  clk,
    input logic                  rst,
    bram_stream_reader_if.master bus
);
    localparam int CW = ((LEN_W > 12) ? LEN_W : 12) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [1:0]    state_q, state_d;
    logic [10:0]   addr_q, addr_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          clamp_q, clamp_d;
    logic          rv_q, rv_d;
    logic          rlast_q, rlast_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    entry_t        b0_q, b0_d, b1_q, b1_d;
    logic [1:0]    cnt_q, cnt_d;

    entry_t        head, rd_ent;
    logic          valid, pop, pop_buf, push, issue;
    logic [CW-1:0] len_ext, eff;
    logic          eff_clamp;
    logic [10:0]   start_addr, addr_inc;
    logic          unused_rdata;

    assign len_ext = CW'(bus.len_i);

`ifdef BRAM_RD_WRAP_EN
    assign eff        = len_ext;
    assign eff_clamp  = 1'b0;
    assign start_addr = bus.base_i & 11'(DEPTH - 1);
    assign addr_inc   = (addr_q == 11'(DEPTH - 1)) ? 11'd0 : addr_q + 11'd1;
`else
    logic [CW-1:0] base_ext, depth_ext, avail;
    assign base_ext   = CW'(bus.base_i);
    assign depth_ext  = CW'(DEPTH);
    assign avail      = (base_ext >= depth_ext) ? '0 : depth_ext - base_ext;
    assign eff        = (len_ext < avail) ? len_ext : avail;
    assign eff_clamp  = (eff != len_ext);
    assign start_addr = bus.base_i;
    assign addr_inc   = addr_q + 11'd1;
`endif

    // rv_q: a read issued last edge, so its word sits on ram_rdata_i this cycle
    assign rd_ent       = '{last: rlast_q, data: bus.ram_rdata_i[DATA_W-1:0]};
    assign unused_rdata = ^bus.ram_rdata_i;

    always_comb begin
        head = '0;
        if (cnt_q != 2'd0) head = b0_q;
        else if (rv_q)     head = rd_ent;
    end

    assign valid   = (cnt_q != 2'd0) || rv_q;
    assign pop     = valid && bus.m_ready_i;
    assign pop_buf = pop && (cnt_q != 2'd0);
    assign push    = rv_q && !(pop && (cnt_q == 2'd0));
    // occupancy after this edge, plus the new read, must stay within two words
    assign issue   = (state_q == S_RUN) &&
                     (({1'b0, cnt_q} + {2'b00, rv_q} - {2'b00, pop}) <= 3'd1);

    always_comb begin
        b0_d  = b0_q;
        b1_d  = b1_q;
        cnt_d = cnt_q;
        if (pop_buf) begin
            b0_d  = b1_q;
            cnt_d = cnt_q - 2'd1;
        end
        if (push) begin
            if (cnt_d == 2'd0) b0_d = rd_ent;
            else               b1_d = rd_ent;
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        clamp_d = clamp_q;
        rv_d    = issue;
        rlast_d = issue && (rem_q == CW'(1));
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    if (eff == '0) begin
                        done_d = 1'b1;
                        err_d  = eff_clamp;
                    end else begin
                        state_d = S_RUN;
                        addr_d  = start_addr;
                        rem_d   = eff;
                        clamp_d = eff_clamp;
                    end
                end
            end
            S_RUN, S_DRAIN: begin
                if (issue) begin
                    addr_d = addr_inc;
                    rem_d  = rem_q - CW'(1);
                    if (rem_q == CW'(1)) state_d = S_DRAIN;
                end
                if (pop && head.last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = clamp_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            clamp_q <= 1'b0;
            rv_q    <= 1'b0;
            rlast_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            b0_q    <= '0;
            b1_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            clamp_q <= clamp_d;
            rv_q    <= rv_d;
            rlast_q <= rlast_d;
            done_q  <= done_d;
            err_q   <= err_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.ram_rclke_o = (state_q != S_IDLE);
    assign bus.ram_re_o    = issue;
    assign bus.ram_raddr_o = addr_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.m_valid_o   = valid;
    assign bus.m_data_o    = head.data;
    assign bus.m_last_o    = head.last;
endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: 16-bit and 4-bit instances against RAM models and a list-based reference.
module tb_bram_stream_reader;
    localparam int DA = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_stream_reader_if #(.DATA_W(16), .LEN_W(12)) ifa ();
    bram_stream_reader_if #(.DATA_W(4),  .LEN_W(12)) ifb ();

    bram_stream_reader #(.DATA_W(16), .DEPTH(256),  .LEN_W(12)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    bram_stream_reader #(.DATA_W(4),  .DEPTH(1024), .LEN_W(12)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    logic [15:0] mem_a [2048];
    logic [15:0] mem_b [2048];

    int checks = 0, failures = 0;
    int gcyc = 0, s_edge = 0, rmode = 0;

    logic [10:0] iss_q [$];
    logic [15:0] acc_d [$];
    bit          acc_l [$];
    int first_re, first_vld, last_acc, done_cyc, n_done, max_out, n_unstable;
    bit done_err, hold_pend, hold_l;
    logic [15:0] hold_d;

    logic [3:0] accb_d [$];
    bit         accb_l [$];
    int nb_done;
    bit nb_err;

    // registered-read RAM models
    always @(posedge clk) begin
        gcyc <= gcyc + 1;
        if (ifa.ram_rclke_o && ifa.ram_re_o) ifa.ram_rdata_i <= mem_a[ifa.ram_raddr_o];
        if (ifb.ram_rclke_o && ifb.ram_re_o) ifb.ram_rdata_i <= mem_b[ifb.ram_raddr_o];
    end

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       ifa.m_ready_i = 1'b1;
            1:       ifa.m_ready_i = (gcyc % 3 == 0);
            default: ifa.m_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin : mon_a
        int cyc;
        if (!rst) begin
            cyc = gcyc - s_edge + 1;
            if (ifa.ram_re_o) begin
                iss_q.push_back(ifa.ram_raddr_o);
                if (first_re < 0) first_re = cyc;
            end
            if (ifa.m_valid_o && first_vld < 0) first_vld = cyc;
            if (ifa.m_valid_o && ifa.m_ready_i) begin
                acc_d.push_back(ifa.m_data_o);
                acc_l.push_back(ifa.m_last_o);
                last_acc = cyc;
            end
            if (ifa.done_o) begin
                n_done++;
                done_cyc = cyc;
                done_err = ifa.err_o;
            end
            if (hold_pend && !(ifa.m_valid_o && ifa.m_data_o === hold_d && ifa.m_last_o === hold_l))
                n_unstable++;
            hold_pend = ifa.m_valid_o && !ifa.m_ready_i;
            hold_d    = ifa.m_data_o;
            hold_l    = ifa.m_last_o;
            if (iss_q.size() - acc_d.size() > max_out) max_out = iss_q.size() - acc_d.size();
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ifb.m_valid_o && ifb.m_ready_i) begin
                accb_d.push_back(ifb.m_data_o);
                accb_l.push_back(ifb.m_last_o);
            end
            if (ifb.done_o) begin
                nb_done++;
                nb_err = ifb.err_o;
            end
        end
    end

    // reference: number of words the reader should deliver for a command
    function automatic int eff_len(input int base, input int len);
`ifdef BRAM_RD_WRAP_EN
        return len;
`else
        if (base >= DA) return 0;
        return (len < DA - base) ? len : DA - base;
`endif
    endfunction

    function automatic int exp_addr(input int base, input int i);
        return (base + i) % DA;
    endfunction

    task automatic clr_mon();
        iss_q.delete(); acc_d.delete(); acc_l.delete();
        first_re = -1; first_vld = -1; last_acc = -1; done_cyc = -1;
        n_done = 0; max_out = 0; n_unstable = 0; done_err = 1'b0; hold_pend = 1'b0;
    endtask

    task automatic xfer(input int base, input int len, input int mode, input int budget);
        clr_mon();
        rmode = mode;
        @(posedge clk); #1;
        ifa.start_i = 1'b1; ifa.base_i = 11'(base); ifa.len_i = 12'(len);
        @(posedge clk); #1;
        s_edge = gcyc; ifa.start_i = 1'b0;
        for (int k = 0; k < budget && n_done == 0; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; #1;
        checks++;
        if ({ifa.busy_o, ifa.done_o, ifa.err_o, ifa.ram_rclke_o, ifa.ram_re_o, ifa.m_valid_o, ifa.m_last_o} !== 7'd0 ||
            ifa.ram_raddr_o !== 11'd0 || ifa.m_data_o !== 16'd0) begin
            failures++; $display("FAIL reset_a busy=%b valid=%b re=%b data=%h exp all zero", ifa.busy_o, ifa.m_valid_o, ifa.ram_re_o, ifa.m_data_o);
        end
        checks++;
        if ({ifb.busy_o, ifb.done_o, ifb.err_o, ifb.ram_rclke_o, ifb.ram_re_o, ifb.m_valid_o, ifb.m_last_o} !== 7'd0 ||
            ifb.ram_raddr_o !== 11'd0 || ifb.m_data_o !== 4'd0) begin
            failures++; $display("FAIL reset_b busy=%b valid=%b re=%b data=%h exp all zero", ifb.busy_o, ifb.m_valid_o, ifb.ram_re_o, ifb.m_data_o);
        end
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        xfer('h10, 4, 0, 40);
        checks++;
        if (acc_d.size() != 4) begin failures++; $display("FAIL basic_count got=%0d exp=4", acc_d.size()); end
        for (int i = 0; i < acc_d.size() && i < 4; i++) begin
            checks++;
            if (acc_d[i] !== 16'('h110 + i) || acc_l[i] !== (i == 3)) begin
                failures++; $display("FAIL basic_word%0d got=%h/%b exp=%h/%b", i, acc_d[i], acc_l[i], 16'('h110 + i), (i == 3));
            end
        end
        checks++;
        if (iss_q.size() != 4) begin failures++; $display("FAIL basic_issues got=%0d exp=4", iss_q.size()); end
        for (int i = 0; i < iss_q.size() && i < 4; i++) begin
            checks++;
            if (iss_q[i] !== 11'('h10 + i)) begin failures++; $display("FAIL basic_addr%0d got=%h exp=%h", i, iss_q[i], 11'('h10 + i)); end
        end
        checks++;
        if (first_re != 1 || first_vld != 2 || last_acc != 5) begin
            failures++; $display("FAIL basic_latency re=%0d vld=%0d last=%0d exp 1/2/5", first_re, first_vld, last_acc);
        end
        checks++;
        if (n_done != 1 || done_cyc != 6 || done_err !== 1'b0) begin
            failures++; $display("FAIL basic_done n=%0d cyc=%0d err=%b exp 1/6/0", n_done, done_cyc, done_err);
        end
    endtask

    task automatic test_backpressure();
        xfer('h10, 4, 1, 80);
        checks++;
        if (acc_d.size() != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", acc_d.size()); end
        for (int i = 0; i < acc_d.size() && i < 4; i++) begin
            checks++;
            if (acc_d[i] !== 16'('h110 + i) || acc_l[i] !== (i == 3)) begin
                failures++; $display("FAIL bp_word%0d got=%h/%b exp=%h/%b", i, acc_d[i], acc_l[i], 16'('h110 + i), (i == 3));
            end
        end
        checks++;
        if (max_out > 2 || n_unstable != 0 || n_done != 1) begin
            failures++; $display("FAIL bp_protocol outstanding=%0d unstable=%0d done=%0d exp <=2/0/1", max_out, n_unstable, n_done);
        end
    endtask

    task automatic test_zero_len();
        xfer('h20, 0, 0, 10);
        checks++;
        if (n_done != 1 || done_cyc != 1 || done_err !== 1'b0) begin
            failures++; $display("FAIL zero_done n=%0d cyc=%0d err=%b exp 1/1/0", n_done, done_cyc, done_err);
        end
        checks++;
        if (iss_q.size() != 0 || first_vld != -1) begin
            failures++; $display("FAIL zero_activity issues=%0d first_vld=%0d exp 0/-1", iss_q.size(), first_vld);
        end
    endtask

    task automatic test_wrap_edge();
        int e;
        e = eff_len(250, 10);
        xfer(250, 10, 0, 60);
        checks++;
        if (acc_d.size() != e || iss_q.size() != e) begin
            failures++; $display("FAIL edge_count words=%0d issues=%0d exp=%0d", acc_d.size(), iss_q.size(), e);
        end
        for (int i = 0; i < acc_d.size() && i < e && i < iss_q.size(); i++) begin
            checks++;
            if (iss_q[i] !== 11'(exp_addr(250, i)) || acc_d[i] !== mem_a[exp_addr(250, i)] || acc_l[i] !== (i == e - 1)) begin
                failures++; $display("FAIL edge_word%0d addr=%0d data=%h last=%b exp %0d/%h/%b", i, iss_q[i], acc_d[i], acc_l[i],
                                     exp_addr(250, i), mem_a[exp_addr(250, i)], (i == e - 1));
            end
        end
        checks++;
        if (n_done != 1 || done_cyc != e + 2 || done_err !== (e != 10)) begin
            failures++; $display("FAIL edge_done n=%0d cyc=%0d err=%b exp 1/%0d/%b", n_done, done_cyc, done_err, e + 2, (e != 10));
        end
    endtask

    task automatic test_reset_mid();
        clr_mon();
        rmode = 0;
        @(posedge clk); #1;
        ifa.start_i = 1'b1; ifa.base_i = 11'h40; ifa.len_i = 12'd8;
        @(posedge clk); #1;
        s_edge = gcyc; ifa.start_i = 1'b0;
        @(posedge clk); @(posedge clk);
        #3; rst = 1'b1; #1;
        checks++;
        if ({ifa.busy_o, ifa.done_o, ifa.err_o, ifa.ram_rclke_o, ifa.ram_re_o, ifa.m_valid_o, ifa.m_last_o} !== 7'd0 ||
            ifa.ram_raddr_o !== 11'd0 || ifa.m_data_o !== 16'd0) begin
            failures++; $display("FAIL midrst_outputs busy=%b valid=%b re=%b addr=%h exp all zero", ifa.busy_o, ifa.m_valid_o, ifa.ram_re_o, ifa.ram_raddr_o);
        end
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        n_done = 0; first_vld = -1;
        repeat (10) @(posedge clk); #1;
        checks++;
        if (n_done != 0 || first_vld != -1 || ifa.busy_o !== 1'b0) begin
            failures++; $display("FAIL midrst_quiet done=%0d first_vld=%0d busy=%b exp 0/-1/0", n_done, first_vld, ifa.busy_o);
        end
        xfer(0, 2, 0, 30);
        checks++;
        if (acc_d.size() != 2 || n_done != 1 || done_cyc != 4) begin
            failures++; $display("FAIL midrst_restart words=%0d done=%0d cyc=%0d exp 2/1/4", acc_d.size(), n_done, done_cyc);
        end
        for (int i = 0; i < acc_d.size() && i < 2; i++) begin
            checks++;
            if (acc_d[i] !== mem_a[i] || acc_l[i] !== (i == 1)) begin
                failures++; $display("FAIL midrst_word%0d got=%h/%b exp=%h/%b", i, acc_d[i], acc_l[i], mem_a[i], (i == 1));
            end
        end
    endtask

    task automatic test_narrow();
        logic [15:0] w;
        accb_d.delete(); accb_l.delete(); nb_done = 0; nb_err = 1'b0;
        @(posedge clk); #1;
        ifb.start_i = 1'b1; ifb.base_i = 11'd1020; ifb.len_i = 12'd4;
        @(posedge clk); #1; ifb.start_i = 1'b0;
        @(posedge clk); #1; ifb.start_i = 1'b1; ifb.base_i = 11'd0; ifb.len_i = 12'd5;
        @(posedge clk); #1; ifb.start_i = 1'b1;
        @(posedge clk); #1; ifb.start_i = 1'b0;
        repeat (12) @(posedge clk); #1;
        checks++;
        if (accb_d.size() != 4 || nb_done != 1 || nb_err !== 1'b0) begin
            failures++; $display("FAIL narrow_xfer words=%0d done=%0d err=%b exp 4/1/0", accb_d.size(), nb_done, nb_err);
        end
        for (int i = 0; i < accb_d.size() && i < 4; i++) begin
            w = mem_b[1020 + i];
            checks++;
            if (accb_d[i] !== w[3:0] || accb_l[i] !== (i == 3)) begin
                failures++; $display("FAIL narrow_word%0d got=%h/%b exp=%h/%b", i, accb_d[i], accb_l[i], w[3:0], (i == 3));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2048; i++) mem_a[i] = 16'($urandom);
        for (int t = 0; t < 14; t++) begin
            int b, l, e;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(0, DA - 1);
                1:       b = DA - 1 - $urandom_range(0, 8);
                2:       b = $urandom_range(0, 2047);
                default: b = $urandom_range(0, 31);
            endcase
            l = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 24);
            e = eff_len(b, l);
            xfer(b, l, 2, 30 * l + 40);
            checks++;
            if (n_done != 1 || done_err !== (e != l)) begin
                failures++; $display("FAIL rand%0d_done base=%0d len=%0d n=%0d err=%b exp 1/%b", t, b, l, n_done, done_err, (e != l));
            end
            checks++;
            if (acc_d.size() != e) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", t, acc_d.size(), e); end
            for (int i = 0; i < acc_d.size() && i < e; i++) begin
                checks++;
                if (acc_d[i] !== mem_a[exp_addr(b, i)] || acc_l[i] !== (i == e - 1)) begin
                    failures++; $display("FAIL rand%0d_word%0d got=%h/%b exp=%h/%b", t, i, acc_d[i], acc_l[i], mem_a[exp_addr(b, i)], (i == e - 1));
                end
            end
            checks++;
            if (max_out > 2 || n_unstable != 0) begin
                failures++; $display("FAIL rand%0d_protocol outstanding=%0d unstable=%0d exp <=2/0", t, max_out, n_unstable);
            end
        end
    endtask

    initial begin
        ifa.start_i = 1'b0; ifa.base_i = '0; ifa.len_i = '0;
        ifb.start_i = 1'b0; ifb.base_i = '0; ifb.len_i = '0; ifb.m_ready_i = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            mem_a[i] = 16'(i + 'h100);
            mem_b[i] = 16'($urandom);
        end
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_wrap_edge();
        test_reset_mid();
        test_narrow();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
